// File: rtl/iq_shift_param_if.sv
// Dispatch/CDB/issue bus of the shifting issue queue.
// master drives dispatch, CDB and grant; slave is the queue itself.
interface iq_shift_param_if #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned PID_W = 6,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 4
);
  logic             du_w_en;
  logic [0:WIDTH-1] du_w_din;
  logic             iq_full;
  logic [CNT_W-1:0] iq_count;
  logic             cdb_flush;
  logic [TAG_W-1:0] cdb_rob_tag;
  logic [TAG_W-1:0] rob_r_ptr;
  logic             cdb_reg_wr;
  logic [PID_W-1:0] cdb_rd_pid;
  logic             iq_rdy;
  logic [0:WIDTH-1] iq_r_dout;
  logic             iu_r_en;

  modport master (
    output du_w_en, du_w_din, cdb_flush, cdb_rob_tag, rob_r_ptr,
           cdb_reg_wr, cdb_rd_pid, iu_r_en,
    input  iq_full, iq_count, iq_rdy, iq_r_dout
  );

  modport slave (
    input  du_w_en, du_w_din, cdb_flush, cdb_rob_tag, rob_r_ptr,
           cdb_reg_wr, cdb_rd_pid, iu_r_en,
    output iq_full, iq_count, iq_rdy, iq_r_dout
  );
endinterface

// File: rtl/iq_shift_param.sv
// Parametrised age-ordered shifting issue queue between dispatch and issue.
// Entry 0 is the oldest; one hole is closed per cycle by shifting toward the head.
// Optional macro IQ_BYPASS_WAKEUP_EN: wake up sources of the entry being
// written from the CDB broadcast of the same cycle.
module iq_shift_param #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned WIDTH      = 30,
  parameter int unsigned VALID_LOC  = 0,
  parameter int unsigned RS_RDY_LOC = 1,
  parameter int unsigned RT_RDY_LOC = 2,
  parameter int unsigned RS_LOC     = 3,
  parameter int unsigned RT_LOC     = 9,
  parameter int unsigned PID_W      = 6,
  parameter int unsigned TAG_LOC    = 15,
  parameter int unsigned TAG_W      = 5
) (
  input logic            clk,
  input logic            reset,
  iq_shift_param_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [0:WIDTH-1] mem [DEPTH];
  logic [0:WIDTH-1] upd [DEPTH];
  logic [0:WIDTH-1] nxt [DEPTH];
  logic [0:WIDTH-1] wr_val;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] rdy;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] hole;
  logic             any_rdy;
  logic             full;
  logic             issue;
  logic             accept;
  logic [TAG_W-1:0] flush_age;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Per-entry valid and ready vectors
  always_comb begin
    valid = '0;
    rdy   = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      valid[j] = mem[j][VALID_LOC];
      rdy[j]   = mem[j][VALID_LOC] & mem[j][RS_RDY_LOC] & mem[j][RT_RDY_LOC];
    end
  end

  // Oldest ready entry and lowest hole (descending scan keeps the lowest index)
  always_comb begin
    sel  = '0;
    hole = '0;
    for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
      if (rdy[j])   sel  = IDX_W'(j);
      if (!valid[j]) hole = IDX_W'(j);
    end
  end

  assign any_rdy       = |rdy;
  assign full          = &valid;
  assign bus.iq_rdy    = any_rdy & ~bus.cdb_flush;
  assign bus.iq_r_dout = any_rdy ? mem[sel] : '0;
  assign bus.iq_full   = full;
  assign bus.iq_count  = count_q;
  assign issue         = bus.iu_r_en & bus.iq_rdy;
  assign accept        = bus.du_w_en & ~full & ~bus.cdb_flush;
  assign flush_age     = TAG_W'(bus.cdb_rob_tag - bus.rob_r_ptr);

  // Value stored for an accepted dispatch write
  always_comb begin
    wr_val = bus.du_w_din;
`ifdef IQ_BYPASS_WAKEUP_EN
    if (bus.cdb_reg_wr) begin
      if (bus.du_w_din[RS_LOC +: PID_W] == bus.cdb_rd_pid) wr_val[RS_RDY_LOC] = 1'b1;
      if (bus.du_w_din[RT_LOC +: PID_W] == bus.cdb_rd_pid) wr_val[RT_RDY_LOC] = 1'b1;
    end
`endif
  end

  // In-place update: selective flush, or wakeup plus issue
  always_comb begin
    for (int j = 0; j < int'(DEPTH); j++) begin
      upd[j] = mem[j];
      if (bus.cdb_flush) begin
        if (TAG_W'(mem[j][TAG_LOC +: TAG_W] - bus.rob_r_ptr) >= flush_age) upd[j] = '0;
      end else begin
        if (bus.cdb_reg_wr && valid[j]) begin
          if (mem[j][RS_LOC +: PID_W] == bus.cdb_rd_pid) upd[j][RS_RDY_LOC] = 1'b1;
          if (mem[j][RT_LOC +: PID_W] == bus.cdb_rd_pid) upd[j][RT_RDY_LOC] = 1'b1;
        end
        if (issue && (sel == IDX_W'(j))) upd[j] = '0;
      end
    end
  end

  // Close the lowest hole by shifting, append the write at the tail, recount
  always_comb begin
    for (int j = 0; j < int'(DEPTH) - 1; j++) begin
      nxt[j] = (!full && (IDX_W'(j) >= hole)) ? upd[j+1] : upd[j];
    end
    nxt[DEPTH-1] = full ? upd[DEPTH-1] : (accept ? wr_val : '0);
    count_d = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      count_d = count_d + CNT_W'(nxt[j][VALID_LOC]);
    end
  end

  // Entry storage and valid count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < int'(DEPTH); j++) mem[j] <= '0;
      count_q <= '0;
    end else begin
      for (int j = 0; j < int'(DEPTH); j++) mem[j] <= nxt[j];
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_iq_shift_param.sv
// Scoreboard bench for iq_shift_param: a list-based age-ordered model predicts
// the outputs of every cycle; a monitor compares them mid-cycle.
module tb_iq_shift_param;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 30;
  localparam int unsigned PID_W = 6;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned CNT_W = 4;
`ifdef IQ_BYPASS_WAKEUP_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [0:WIDTH-1] entry_t;
  typedef struct {
    logic             rdy;
    logic             full;
    logic [CNT_W-1:0] count;
    entry_t           dout;
  } exp_t;
  typedef struct {
    logic             w_en;
    entry_t           din;
    logic             flush;
    logic [TAG_W-1:0] ctag;
    logic [TAG_W-1:0] ptr;
    logic             reg_wr;
    logic [PID_W-1:0] pid;
    logic             r_en;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  entry_t model_q[$];
  exp_t   exp_q[$];

  always #5 clk = ~clk;

  iq_shift_param_if #(.WIDTH(WIDTH), .PID_W(PID_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  iq_shift_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PID_W(PID_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic entry_t mk(logic rsr, logic rtr, logic [PID_W-1:0] rs,
                                logic [PID_W-1:0] rt, logic [TAG_W-1:0] tag);
    entry_t e;
    e = '0;
    e[0] = 1'b1;
    e[1] = rsr;
    e[2] = rtr;
    e[3 +: 6] = rs;
    e[9 +: 6] = rt;
    e[15 +: 5] = tag;
    e[20 +: 10] = 10'($urandom);
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.w_en = 1'b0; s.din = '0; s.flush = 1'b0; s.ctag = '0; s.ptr = '0;
    s.reg_wr = 1'b0; s.pid = '0; s.r_en = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.du_w_en     = s.w_en;
    bus.du_w_din    = s.din;
    bus.cdb_flush   = s.flush;
    bus.cdb_rob_tag = s.ctag;
    bus.rob_r_ptr   = s.ptr;
    bus.cdb_reg_wr  = s.reg_wr;
    bus.cdb_rd_pid  = s.pid;
    bus.iu_r_en     = s.r_en;
  endtask

  // One clock of stimulus: predict this cycle's outputs, then advance the model
  task automatic step(input stim_t s);
    exp_t   e;
    entry_t keep[$];
    entry_t n;
    int     fr;
    @(posedge clk); #1;
    apply(s);
    fr = -1;
    foreach (model_q[i]) if (fr < 0 && model_q[i][0] && model_q[i][1] && model_q[i][2]) fr = i;
    e.dout  = (fr >= 0) ? model_q[fr] : '0;
    e.rdy   = (fr >= 0) && !s.flush;
    e.full  = (model_q.size() == int'(DEPTH));
    e.count = CNT_W'(model_q.size());
    exp_q.push_back(e);
    if (s.flush) begin
      keep = {};
      foreach (model_q[i])
        if (TAG_W'(model_q[i][15 +: 5] - s.ptr) < TAG_W'(s.ctag - s.ptr)) keep.push_back(model_q[i]);
      model_q = keep;
    end else begin
      if (s.r_en && e.rdy) model_q.delete(fr);
      if (s.reg_wr) begin
        foreach (model_q[i]) begin
          if (model_q[i][3 +: 6] == s.pid) model_q[i][1] = 1'b1;
          if (model_q[i][9 +: 6] == s.pid) model_q[i][2] = 1'b1;
        end
      end
      if (s.w_en && !e.full) begin
        n = s.din;
        if (BYP && s.reg_wr) begin
          if (n[3 +: 6] == s.pid) n[1] = 1'b1;
          if (n[9 +: 6] == s.pid) n[2] = 1'b1;
        end
        model_q.push_back(n);
      end
    end
  endtask

  // Mid-stream asynchronous reset, held for one cycle
  task automatic do_reset();
    exp_t e;
    e.rdy = 1'b0; e.full = 1'b0; e.count = '0; e.dout = '0;
    @(posedge clk); #1;
    apply(idle());
    reset = 1'b0;
    model_q.delete();
    exp_q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest pending prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("iq_rdy",    32'(bus.iq_rdy),    32'(e.rdy));
        chk("iq_full",   32'(bus.iq_full),   32'(e.full));
        chk("iq_count",  32'(bus.iq_count),  32'(e.count));
        chk("iq_r_dout", 32'(bus.iq_r_dout), 32'(e.dout));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stim_t  s;
    entry_t we;
    reset = 1'b0;
    apply(idle());
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_count", 32'(bus.iq_count), 32'd0);
    chk("reset_rdy",   32'(bus.iq_rdy),   32'd0);
    chk("reset_full",  32'(bus.iq_full),  32'd0);
    chk("reset_dout",  32'(bus.iq_r_dout), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Mid-stream reset with five valid entries
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.w_en = 1'b1; s.din = mk(1'b1, 1'b1, 6'd1, 6'd2, 5'(i)); step(s);
    end
    do_reset();

    // Fill to full, drop a ninth write, then free one slot
    for (int i = 0; i < 9; i++) begin
      s = idle(); s.w_en = 1'b1; s.din = mk(1'b1, 1'b1, 6'd1, 6'd2, 5'(i)); step(s);
    end
    step(idle());
    @(negedge clk);
    chk("fill_count", 32'(bus.iq_count), 32'd8);
    chk("fill_full",  32'(bus.iq_full),  32'd1);
    s = idle(); s.r_en = 1'b1; step(s);
    step(idle());
    @(negedge clk);
    chk("after_issue_full", 32'(bus.iq_full), 32'd0);
    for (int i = 0; i < 8; i++) begin
      s = idle(); s.r_en = 1'b1; step(s);
    end

    // Wakeup of an rs source on pid 12
    we = mk(1'b0, 1'b1, 6'd12, 6'd3, 5'd4);
    s = idle(); s.w_en = 1'b1; s.din = we; step(s);
    step(idle());
    s = idle(); s.reg_wr = 1'b1; s.pid = 6'd12; step(s);
    step(idle());
    @(negedge clk);
    chk("wakeup_rdy",  32'(bus.iq_rdy),    32'd1);
    chk("wakeup_dout", 32'(bus.iq_r_dout), 32'({we[0:0], 1'b1, we[2:29]}));
    s = idle(); s.r_en = 1'b1; step(s);

    // Flush across the tag wrap: ptr 30, tags 30,31,0,1,2, flush tag 0
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.w_en = 1'b1; s.din = mk(1'b0, 1'b1, 6'd40, 6'd41, 5'(30 + i)); step(s);
    end
    s = idle(); s.flush = 1'b1; s.ctag = 5'd0; s.ptr = 5'd30; step(s);
    step(idle());
    @(negedge clk);
    chk("flush_wrap_count", 32'(bus.iq_count), 32'd2);
    s = idle(); s.flush = 1'b1; s.ctag = 5'd30; s.ptr = 5'd30; step(s);

    // Age order: tags 3 and 7 become ready with a hole between them
    s = idle(); s.w_en = 1'b1; s.din = mk(1'b0, 1'b1, 6'd20, 6'd21, 5'd3); step(s);
    s = idle(); s.w_en = 1'b1; s.din = mk(1'b1, 1'b1, 6'd22, 6'd23, 5'd5); step(s);
    s = idle(); s.w_en = 1'b1; s.din = mk(1'b0, 1'b1, 6'd20, 6'd24, 5'd7); step(s);
    s = idle(); s.r_en = 1'b1; step(s);
    s = idle(); s.reg_wr = 1'b1; s.pid = 6'd20; step(s);
    step(idle());
    @(negedge clk);
    chk("age_first_tag", 32'(bus.iq_r_dout[15 +: 5]), 32'd3);
    repeat (3) begin
      s = idle(); s.r_en = 1'b1; step(s);
    end

    // Same-cycle CDB broadcast on the rt pid of a dispatched entry
    s = idle(); s.w_en = 1'b1; s.din = mk(1'b1, 1'b0, 6'd30, 6'd9, 5'd11);
    s.reg_wr = 1'b1; s.pid = 6'd9; step(s);
    step(idle());
    @(negedge clk);
    chk("bypass_rdy", 32'(bus.iq_rdy), 32'(BYP));
    s = idle(); s.flush = 1'b1; s.ctag = 5'd0; s.ptr = 5'd0; step(s);

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        s.w_en   = ($urandom_range(0, 3) != 0);
        s.din    = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 5'($urandom));
        s.flush  = ($urandom_range(0, 19) == 0);
        s.ctag   = 5'($urandom);
        s.ptr    = 5'($urandom);
        s.reg_wr = 1'($urandom_range(0, 1));
        s.pid    = 6'($urandom_range(0, 7));
        s.r_en   = ($urandom_range(0, 2) != 0);
        step(s);
      end
    end

    step(idle());
    @(negedge clk); #1;
    chk("pending_predictions", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
